// File: rtl/adc_frame_capture.sv
// Captures one frame of offset-binary ADC samples into a local buffer on a start
// key edge, then streams them as signed 16-bit words over a valid/ready port.
module adc_frame_capture #(
  parameter int FRAME_LEN = 256,
  parameter int DECIM     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  ad_data,
  input  logic        ad_otr,
  output logic [15:0] fft_data,
  output logic        fft_valid,
  input  logic        fft_ready,
  output logic        fft_last,
  output logic        busy,
  output logic        frame_done,
  output logic        ovr,
  output logic [1:0]  dbg_state_o
);

  localparam int IDXW = $clog2(FRAME_LEN);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(FRAME_LEN - 1);
  localparam logic [15:0]     DEC_LAST = 16'(DECIM - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_STREAM  = 2'd2
  } state_t;

  state_t          state_q;
  logic            start_prev_q;
  logic [IDXW-1:0] wr_idx_q;
  logic [IDXW-1:0] rd_idx_q;
  logic [15:0]     dec_cnt_q;
  logic [15:0]     fft_data_q;
  logic            fft_valid_q;
  logic            fft_last_q;
  logic            busy_q;
  logic            frame_done_q;
  logic            ovr_q;

  logic [9:0] buf_mem [FRAME_LEN];

  logic start_edge_d;
  logic store_en_d;
  logic xfer_d;

  // Handshake: a word moves on any clock where fft_valid and fft_ready are both
  // high; while fft_valid is high and fft_ready low the output word is frozen.
  assign start_edge_d = start & ~start_prev_q;
  assign store_en_d   = (state_q == S_CAPTURE) && (dec_cnt_q == 16'd0);
  assign xfer_d       = fft_valid_q & fft_ready;

  // Offset binary to two's complement: flipping the MSB subtracts 512.
  function automatic logic [15:0] to_signed16(input logic [9:0] s);
    logic [9:0] c;
    c = {~s[9], s[8:0]};
    return {{6{c[9]}}, c};
  endfunction

  always_ff @(posedge clk) begin
    if (store_en_d) begin
      buf_mem[wr_idx_q] <= ad_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      dec_cnt_q    <= '0;
      fft_data_q   <= '0;
      fft_valid_q  <= 1'b0;
      fft_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      start_prev_q <= start;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // An edge coinciding with the done pulse is dropped, not deferred.
          if (start_edge_d && !frame_done_q) begin
            state_q   <= S_CAPTURE;
            wr_idx_q  <= '0;
            dec_cnt_q <= '0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (store_en_d) begin
            ovr_q    <= ovr_q | ad_otr;
            wr_idx_q <= wr_idx_q + IDX_ONE;
            if (wr_idx_q == IDX_LAST) begin
              state_q  <= S_STREAM;
              rd_idx_q <= '0;
            end
          end
          dec_cnt_q <= (dec_cnt_q == DEC_LAST) ? 16'd0 : dec_cnt_q + 16'd1;
        end
        S_STREAM: begin
          if (xfer_d && fft_last_q) begin
            fft_valid_q  <= 1'b0;
            fft_last_q   <= 1'b0;
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end else if (!fft_valid_q || fft_ready) begin
            fft_data_q  <= to_signed16(buf_mem[rd_idx_q]);
            fft_valid_q <= 1'b1;
            fft_last_q  <= (rd_idx_q == IDX_LAST);
            rd_idx_q    <= rd_idx_q + IDX_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fft_data    = fft_data_q;
  assign fft_valid   = fft_valid_q;
  assign fft_last    = fft_last_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign ovr         = ovr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adc_frame_capture.sv
// Directed bench for adc_frame_capture: ramp capture, decimation, stalls,
// over-range flag, ignored start edges and mid-stream reset.
module tb_adc_frame_capture;

  localparam int FL = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start4;
  logic [9:0]  ad_data;
  logic        ad_otr;
  logic        rdy1, rdy4;
  logic [15:0] d1, d4;
  logic        v1, v4, l1, l4, b1, b4, fd1, fd4, o1, o4;
  logic [1:0]  st1, st4;

  bit          use4;
  logic [15:0] o_data;
  logic        o_valid, o_last, o_busy, o_done, o_ovr;
  logic [1:0]  o_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adc_frame_capture #(.FRAME_LEN(FL), .DECIM(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ad_data(ad_data), .ad_otr(ad_otr),
    .fft_data(d1), .fft_valid(v1), .fft_ready(rdy1), .fft_last(l1), .busy(b1),
    .frame_done(fd1), .ovr(o1), .dbg_state_o(st1)
  );

  adc_frame_capture #(.FRAME_LEN(FL), .DECIM(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .ad_data(ad_data), .ad_otr(ad_otr),
    .fft_data(d4), .fft_valid(v4), .fft_ready(rdy4), .fft_last(l4), .busy(b4),
    .frame_done(fd4), .ovr(o4), .dbg_state_o(st4)
  );

  assign o_data  = use4 ? d4  : d1;
  assign o_valid = use4 ? v4  : v1;
  assign o_last  = use4 ? l4  : l1;
  assign o_busy  = use4 ? b4  : b1;
  assign o_done  = use4 ? fd4 : fd1;
  assign o_ovr   = use4 ? o4  : o1;
  assign o_state = use4 ? st4 : st1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: land on the falling edge, then advance the ADC ramp.
  task automatic step();
    @(negedge clk);
    ad_data = ad_data + 10'd1;
  endtask

  task automatic set_start(input logic x);
    if (use4) start4 = x; else start1 = x;
  endtask

  task automatic set_ready(input logic x);
    if (use4) rdy4 = x; else rdy1 = x;
  endtask

  function automatic logic [15:0] exp_sample(input int k, input int decim);
    logic [9:0] v;
    v = 10'((k * decim) & 1023);
    return 16'(int'(v) - 512);
  endfunction

  task automatic run_frame(input bit sel, input int decim, input bit rand_ready,
                           input bit extra_edges, input int otr_at, input int rst_at,
                           input bit edge_on_done);
    int   idx, guard, first_x, last_x, first_v;
    bit   held, r;
    logic [15:0] hd;
    logic hl;
    logic [15:0] exp_q[$];
    use4 = sel;
    for (int k = 0; k < FL; k++) exp_q.push_back(exp_sample(k, decim));
    set_ready(1'b0);
    set_start(1'b0);
    step();
    step();
    ad_data = 10'h3FF;
    set_start(1'b1);
    for (int c = 0; c < FL * decim; c++) begin
      step();
      ad_otr = (c == otr_at);
      if (c == 2) begin
        check_eq("ovr_clear_on_entry", 32'(o_ovr), 32'd0);
        check_eq("busy_capture", 32'(o_busy), 32'd1);
      end
      if (extra_edges && c == 5) set_start(1'b0);
      if (extra_edges && c == 7) set_start(1'b1);
    end
    ad_otr = 1'b0;
    check_eq("ovr_after_capture", 32'(o_ovr), 32'(otr_at >= 0));
    idx = 0; guard = 0; held = 0; first_x = -1; last_x = -1; first_v = -1;
    hd = '0; hl = 1'b0;
    while (idx < FL && guard < 4000) begin
      step();
      guard++;
      if (rst_at >= 0 && idx == rst_at) begin
        rst_n = 1'b0;
        set_start(1'b0);
        #1;
        check_eq("rst_data", 32'(o_data), 32'd0);
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_last", 32'(o_last), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_done", 32'(o_done), 32'd0);
        check_eq("rst_ovr", 32'(o_ovr), 32'd0);
        check_eq("rst_state", 32'(o_state), 32'd0);
        step();
        rst_n = 1'b1;
        set_ready(1'b1);
        repeat (6) step();
        check_eq("post_rst_valid", 32'(o_valid), 32'd0);
        check_eq("post_rst_busy", 32'(o_busy), 32'd0);
        check_eq("post_rst_state", 32'(o_state), 32'd0);
        return;
      end
      r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      set_ready(r);
      if (extra_edges && guard == 50) set_start(1'b0);
      if (extra_edges && guard == 52) set_start(1'b1);
      if (extra_edges && guard == 60) set_start(1'b0);
      if (held) begin
        check_eq("stall_valid", 32'(o_valid), 32'd1);
        check_eq("stall_data", 32'(o_data), 32'(hd));
        check_eq("stall_last", 32'(o_last), 32'(hl));
      end
      if (o_valid && first_v < 0) first_v = guard;
      if (o_valid && r) begin
        check_eq($sformatf("data[%0d]", idx), 32'(o_data), 32'(exp_q[idx]));
        check_eq($sformatf("last[%0d]", idx), 32'(o_last), 32'(idx == FL - 1));
        if (first_x < 0) first_x = guard;
        last_x = guard;
        idx++;
      end
      held = o_valid && !r;
      hd = o_data;
      hl = o_last;
    end
    check_eq("xfer_count", 32'(idx), 32'(FL));
    check_eq("stream_latency_ok", 32'(first_v >= 1 && first_v <= 3), 32'd1);
    if (!rand_ready) check_eq("throughput", 32'(last_x - first_x), 32'(FL - 1));
    step();
    check_eq("done_pulse", 32'(o_done), 32'd1);
    check_eq("done_valid", 32'(o_valid), 32'd0);
    check_eq("done_busy", 32'(o_busy), 32'd0);
    check_eq("done_ovr", 32'(o_ovr), 32'(otr_at >= 0));
    check_eq("done_state", 32'(o_state), 32'd0);
    if (edge_on_done) set_start(1'b1);
    step();
    check_eq("done_one_cycle", 32'(o_done), 32'd0);
    repeat (3) step();
    check_eq("idle_busy", 32'(o_busy), 32'd0);
    check_eq("idle_valid", 32'(o_valid), 32'd0);
    check_eq("idle_ovr_held", 32'(o_ovr), 32'(otr_at >= 0));
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; rdy1 = 1'b0; rdy4 = 1'b0;
    ad_otr = 1'b0; ad_data = '0; use4 = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_data", 32'(d1), 32'd0);
    check_eq("reset_valid", 32'(v1), 32'd0);
    check_eq("reset_last", 32'(l1), 32'd0);
    check_eq("reset_busy", 32'(b1), 32'd0);
    check_eq("reset_done", 32'(fd1), 32'd0);
    check_eq("reset_ovr", 32'(o1), 32'd0);
    check_eq("reset_state", 32'(st1), 32'd0);
    check_eq("reset_valid4", 32'(v4), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // Ramp, DECIM=1, ready held high.
    run_frame(1'b0, 1, 1'b0, 1'b0, -1, -1, 1'b0);
    // Random stalls, over-range on one sample, stray start edges, edge on done.
    run_frame(1'b0, 1, 1'b1, 1'b1, 10, -1, 1'b1);
    // Reset in the middle of the stream.
    run_frame(1'b0, 1, 1'b0, 1'b0, -1, 100, 1'b0);
    // Decimation by 4.
    run_frame(1'b1, 4, 1'b0, 1'b0, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_frame_capture.md
ADC_FRAME_CAPTURE -- requirements
Module: adc_frame_capture

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 256, number of samples per frame (power of two, 16..1024).
REQ-002 SHALL have parameter DECIM, default 1, clocks per captured sample (1..65535).
REQ-003 SHALL have port clk  input  1  capture/stream clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  debounced start key level; rising edge arms a capture.
REQ-006 SHALL have port ad_data  input  10  ADC sample, offset binary.
REQ-007 SHALL have port ad_otr  input  1  ADC over-range flag, aligned with ad_data.
REQ-008 SHALL have port fft_data  output  16  signed sample to FFT input.
REQ-009 SHALL have port fft_valid  output  1  fft_data valid.
REQ-010 SHALL have port fft_ready  input  1  FFT accepts sample when high with fft_valid.
REQ-011 SHALL have port fft_last  output  1  high with the final sample of a frame.
REQ-012 SHALL have port busy  output  1  high in CAPTURE or STREAM.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse after final sample accepted.
REQ-014 SHALL have port ovr  output  1  sticky: any captured sample of current frame had ad_otr=1.

Function
REQ-015 SHALL implement states IDLE, CAPTURE, STREAM; IDLE on reset.
REQ-016 SHALL detect start rising edge with one registered previous value (prev reset 0); edge in IDLE -> CAPTURE next cycle; edge in CAPTURE/STREAM ignored.
REQ-017 On CAPTURE entry SHALL clear write index, decimation counter and ovr.
REQ-018 In CAPTURE SHALL store ad_data into internal FRAME_LEN x 10 buffer at write index when decimation counter = 0, then increment index; counter counts 0..DECIM-1 and wraps.
REQ-019 DECIM=1 SHALL store one sample every cycle; first sample is the ad_data present on the first CAPTURE cycle.
REQ-020 SHALL set ovr on any stored sample with ad_otr=1; ovr holds until next CAPTURE entry.
REQ-021 After storing index FRAME_LEN-1 SHALL move to STREAM; no further ADC samples stored.
REQ-022 In STREAM SHALL present buffer entries 0..FRAME_LEN-1 in order on a registered output; fft_valid rises at most 2 cycles after STREAM entry.
REQ-023 fft_data SHALL equal sign-extended (ad_data - 512): 0x000 -> 0xFE00, 0x200 -> 0x0000, 0x3FF -> 0x01FF.
REQ-024 Transfer occurs on cycle with fft_valid=1 and fft_ready=1; fft_data, fft_last, fft_valid SHALL stay stable while fft_valid=1 and fft_ready=0.
REQ-025 After a transfer the next sample SHALL be valid the following cycle (full throughput when fft_ready held high); no sample skipped or duplicated.
REQ-026 fft_last SHALL be 1 only with sample FRAME_LEN-1.
REQ-027 On transfer of the last sample: fft_valid=0 next cycle, frame_done=1 for exactly that cycle, state -> IDLE, busy=0.
REQ-028 fft_ready while fft_valid=0 SHALL have no effect.
REQ-029 Start edge on the same cycle as frame_done SHALL be ignored; a new edge is required.

Reset
REQ-030 rst_n low SHALL immediately force IDLE; fft_data=0, fft_valid=0, fft_last=0, busy=0, frame_done=0, ovr=0, indices and counters 0.
REQ-031 Reset mid-CAPTURE or mid-STREAM SHALL abandon the frame; after release no output until a new start edge.
REQ-032 Buffer contents need not be reset.

Verification
REQ-033 Ramp ad_data 0,1,2.. per cycle, DECIM=1, start edge, fft_ready=1 -> 256 transfers, data 0xFE00..0xFEFF, fft_last on 256th, frame_done one cycle later-aligned per REQ-027.
REQ-034 DECIM=4, ramp per cycle -> streamed samples step by 4 (offset -512), exactly 256 transfers.
REQ-035 Random fft_ready toggling -> data stable while stalled, sequence identical to ready=1 case, no loss/duplication.
REQ-036 ad_otr=1 for one stored sample -> ovr=1 through frame end; new start edge -> ovr=0 on CAPTURE entry.
REQ-037 Start edges during CAPTURE and STREAM -> ignored, single frame produced; rst_n pulse mid-STREAM -> all outputs 0, idle until next edge.
